seven_segments_mux_n: RTL and testbench

Parametrised multiplexed seven-segment display driver, the successor to the fixed 3-digit handler. It scans `DIGITS` common-anode or common-cathode digits and decodes hex nibbles. It adds leading-zero blanking, per-digit dots, PWM brightness, an anti-ghosting guard interval and tear-free double-buffered updates. It sits between system-level debug/status values and the board's `display_7seg_bus`/`display_7seg_anodes` pins.

---
 rtl/seven_segments_mux_n.sv | 172 +++++++++++++++++
 tb/tb_seven_segments_mux_n.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segments_mux_n.sv
// ============================================================================
// Module      : seven_segments_mux_n
// Description : Multiplexed N-digit seven-segment driver with hex decode,
//               leading-zero blanking, per-digit dots, PWM brightness,
//               anti-ghosting guard interval and double-buffered updates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segments_mux_n #(
   parameter int DIGITS           = 3,
   parameter int REFRESH_DIV      = 50000,
   parameter int PWM_BITS         = 4,
   parameter int GUARD            = 4,
   parameter bit ANODE_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dots,
   input  logic                  blank_lz,
   input  logic [PWM_BITS-1:0]   brightness,
   input  logic                  enable,
   output logic [7:0]            display_7seg_bus,
   output logic [DIGITS-1:0]     display_7seg_anodes,
   output logic                  update_pending,
   output logic                  frame_tick
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0]    GUARD_END  = DIV_W'(GUARD);
   localparam logic [DIG_W-1:0]    DIG_LAST   = DIG_W'(DIGITS - 1);
   localparam logic [DIV_W-1:0]    DIV_ONE    = DIV_W'(1);
   localparam logic [DIG_W-1:0]    DIG_ONE    = DIG_W'(1);
   localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);
   localparam logic [7:0]          BUS_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0]   ANODES_OFF = {DIGITS{ANODE_ACTIVE_LOW}};

   // Scan state
   logic [DIV_W-1:0]    div_cnt;
   logic [DIG_W-1:0]    dig;
   logic [PWM_BITS-1:0] pwm_cnt;

   // Pending (written by load) and active (displayed) buffers
   logic [4*DIGITS-1:0] pend_value, act_value;
   logic [DIGITS-1:0]   pend_dots, act_dots;
   logic                pend_blz, act_blz;

   // Combinational scan decode
   logic                slot_end;
   logic                frame_end;
   logic [3:0]          sel_nib;
   logic                sel_dot;
   logic                sel_blank;
   logic                upper_zero;
   logic [6:0]          seg;
   logic [7:0]          raw_bus;
   logic                digit_on;
   logic [DIGITS-1:0]   anode_on;

   // Hex nibble to segments g..a, active-high
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (dig == DIG_LAST);

   // Select the scanned digit; walk from the top down so the blanking flag
   // knows whether every more-significant nibble is zero
   always_comb begin
      sel_nib    = 4'h0;
      sel_dot    = 1'b0;
      sel_blank  = 1'b0;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero && (act_value[4*i +: 4] == 4'h0);
         if (dig == DIG_W'(i)) begin
            sel_nib   = act_value[4*i +: 4];
            sel_dot   = act_dots[i];
            sel_blank = act_blz && upper_zero && (i != 0);
         end
      end
   end

   // Segment pattern and single-anode enable for the scanned digit
   always_comb begin
      seg      = sel_blank ? 7'h00 : hex_to_seg(sel_nib);
      raw_bus  = {sel_dot, seg};
      digit_on = enable && (div_cnt >= GUARD_END) && (pwm_cnt < brightness);
      anode_on = '0;
      for (int i = 0; i < DIGITS; i++) begin
         anode_on[i] = digit_on && (dig == DIG_W'(i));
      end
   end

   // Slot prescaler, digit index and free-running PWM counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         dig     <= '0;
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_ONE;
         if (slot_end) begin
            div_cnt <= '0;
            dig     <= (dig == DIG_LAST) ? '0 : dig + DIG_ONE;
         end else begin
            div_cnt <= div_cnt + DIV_ONE;
         end
      end
   end

   // Double buffer: loads go to pending, promoted only at the frame boundary;
   // a load on the boundary itself bypasses straight to the active set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_value     <= '0;
         pend_dots      <= '0;
         pend_blz       <= 1'b0;
         act_value      <= '0;
         act_dots       <= '0;
         act_blz        <= 1'b0;
         update_pending <= 1'b0;
      end else if (load) begin
         pend_value <= value;
         pend_dots  <= dots;
         pend_blz   <= blank_lz;
         if (frame_end) begin
            act_value      <= value;
            act_dots       <= dots;
            act_blz        <= blank_lz;
            update_pending <= 1'b0;
         end else begin
            update_pending <= 1'b1;
         end
      end else if (frame_end && update_pending) begin
         act_value      <= pend_value;
         act_dots       <= pend_dots;
         act_blz        <= pend_blz;
         update_pending <= 1'b0;
      end
   end

   // Registered pins with polarity applied, plus the frame pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         display_7seg_bus    <= BUS_OFF;
         display_7seg_anodes <= ANODES_OFF;
         frame_tick          <= 1'b0;
      end else begin
         display_7seg_bus    <= SEG_ACTIVE_LOW ? ~raw_bus : raw_bus;
         display_7seg_anodes <= ANODE_ACTIVE_LOW ? ~anode_on : anode_on;
         frame_tick          <= frame_end;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seven_segments_mux_n.sv
// ============================================================================
// Module      : tb_seven_segments_mux_n
// Description : Scoreboard bench for seven_segments_mux_n (3 digits, 8-cycle
//               slots, 2-bit PWM, 1 guard cycle, active-low pins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segments_mux_n;

   localparam int ND   = 3;
   localparam int SLOT = 8;
   localparam int FRM  = ND * SLOT;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [11:0] value = '0;
   logic [2:0]  dots = '0;
   logic        blank_lz = 1'b0;
   logic [1:0]  brightness = 2'd3;
   logic        enable = 1'b1;
   logic [7:0]  display_7seg_bus;
   logic [2:0]  display_7seg_anodes;
   logic        update_pending;
   logic        frame_tick;

   int n_checks = 0;
   int n_fail   = 0;

   seven_segments_mux_n #(
      .DIGITS(ND), .REFRESH_DIV(SLOT), .PWM_BITS(2), .GUARD(1),
      .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .dots(dots),
      .blank_lz(blank_lz), .brightness(brightness), .enable(enable),
      .display_7seg_bus(display_7seg_bus), .display_7seg_anodes(display_7seg_anodes),
      .update_pending(update_pending), .frame_tick(frame_tick));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [7:0] bus;
      logic [2:0] an;
      logic       pend;
      logic       tick;
   } exp_t;

   exp_t        sb[$];
   int          mt;              // clock edges since reset release
   logic [11:0] m_act_val, m_pend_val;
   logic [2:0]  m_act_dots, m_pend_dots;
   logic        m_act_blz, m_pend_blz, m_flag;
   int          m_d, m_pos, m_pw;
   logic [3:0]  m_nib;
   logic        m_blank, m_on, m_bnd;
   logic [7:0]  m_raw;
   exp_t        m_e;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mt = 0;
         m_act_val = '0; m_pend_val = '0;
         m_act_dots = '0; m_pend_dots = '0;
         m_act_blz = 1'b0; m_pend_blz = 1'b0; m_flag = 1'b0;
         sb.delete();
      end else begin
         m_d     = (mt / SLOT) % ND;
         m_pos   = mt % SLOT;
         m_pw    = mt % 4;
         m_nib   = 4'((m_act_val >> (4 * m_d)) & 12'hF);
         m_blank = (m_d > 0) && m_act_blz && ((m_act_val >> (4 * m_d)) == 12'h0);
         m_raw   = {m_act_dots[m_d], (m_blank ? 7'h00 : SEG_TAB[m_nib])};
         m_on    = enable && (m_pos >= 1) && (m_pw < int'(brightness));
         m_bnd   = (mt % FRM) == FRM - 1;
         m_e.bus = ~m_raw;
         m_e.an  = m_on ? ~(3'b001 << m_d) : 3'b111;
         m_e.tick = m_bnd;
         if (load) begin
            if (m_bnd) begin
               m_act_val = value; m_act_dots = dots; m_act_blz = blank_lz;
               m_flag = 1'b0;
            end else begin
               m_pend_val = value; m_pend_dots = dots; m_pend_blz = blank_lz;
               m_flag = 1'b1;
            end
         end else if (m_bnd && m_flag) begin
            m_act_val = m_pend_val; m_act_dots = m_pend_dots; m_act_blz = m_pend_blz;
            m_flag = 1'b0;
         end
         m_e.pend = m_flag;
         sb.push_back(m_e);
         mt++;
      end
   end

   // Monitor: pop one expectation per output update
   exp_t mon_e;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         check("rst_bus", display_7seg_bus, 8'hFF);
         check("rst_anodes", display_7seg_anodes, 3'b111);
         check("rst_pending", update_pending, 1'b0);
         check("rst_tick", frame_tick, 1'b0);
      end else if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         mon_e = sb.pop_front();
         check("bus", display_7seg_bus, mon_e.bus);
         check("anodes", display_7seg_anodes, mon_e.an);
         check("update_pending", update_pending, mon_e.pend);
         check("frame_tick", frame_tick, mon_e.tick);
      end
   end

   // ---------------- stimulus helpers (called just after a negedge) ----------------
   task automatic do_load(input logic [11:0] v, input logic [2:0] d, input logic b);
      value = v; dots = d; blank_lz = b; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_phase(input int ph);
      int k = 0;
      while ((mt % FRM) != ph && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check("wait_phase_timeout", 1, 0);
   endtask

   task automatic wait_anode(input logic [2:0] pat, input logic [7:0] exp, input string name);
      int k = 0;
      while (display_7seg_anodes !== pat && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (k >= 60) check({name, "_timeout"}, 1, 0);
      else check(name, display_7seg_bus, exp);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset release, two full frames of default (all-zero) content
      repeat (2 * FRM + 2) @(negedge clk);

      // Load and decode
      do_load(12'h3A5, 3'b010, 1'b0);
      check("pending_after_load", update_pending, 1'b1);
      wait_phase(FRM - 1);
      repeat (2) @(negedge clk);
      wait_anode(3'b110, 8'h92, "dec_digit0");
      wait_anode(3'b101, 8'h08, "dec_digit1");
      wait_anode(3'b011, 8'hB0, "dec_digit2");

      // Leading-zero blanking
      wait_phase(5);
      do_load(12'h005, 3'b100, 1'b1);
      wait_phase(FRM - 1);
      repeat (2) @(negedge clk);
      wait_anode(3'b110, 8'h92, "lz_digit0");
      wait_anode(3'b101, 8'hFF, "lz_digit1");
      wait_anode(3'b011, 8'h7F, "lz_digit2");
      do_load(12'h000, 3'b000, 1'b1);
      wait_phase(FRM - 1);
      repeat (2) @(negedge clk);
      wait_anode(3'b110, 8'hC0, "lz_zero_digit0");

      // Tear-free update: two loads in one frame, then a load on the boundary
      wait_phase(10);
      do_load(12'h111, 3'b000, 1'b0);
      wait_phase(14);
      do_load(12'h222, 3'b000, 1'b0);
      wait_phase(FRM - 1);
      repeat (FRM + 2) @(negedge clk);
      wait_phase(FRM - 1);
      do_load(12'h7C9, 3'b001, 1'b0);
      check("boundary_load_pending", update_pending, 1'b0);
      repeat (FRM) @(negedge clk);

      // Brightness and enable
      brightness = 2'd0;
      repeat (FRM) @(negedge clk);
      brightness = 2'd1;
      repeat (FRM) @(negedge clk);
      brightness = 2'd3;
      enable = 1'b0;
      repeat (FRM + 4) @(negedge clk);
      enable = 1'b1;

      // Reset mid-frame with a pending load
      wait_phase(9);
      do_load(12'hBEE, 3'b111, 1'b0);
      wait_phase(12);
      #2 rst = 1'b1;
      #1;
      check("async_rst_bus", display_7seg_bus, 8'hFF);
      check("async_rst_anodes", display_7seg_anodes, 3'b111);
      check("async_rst_pending", update_pending, 1'b0);
      check("async_rst_tick", frame_tick, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (FRM + 2) @(negedge clk);
      wait_anode(3'b011, 8'hC0, "post_rst_digit2");

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         brightness = 2'($urandom_range(0, 3));
         enable     = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 11) == 0) begin
            case ($urandom_range(0, 3))
               0: value = 12'($urandom);
               1: value = 12'($urandom) & 12'h0FF;
               2: value = 12'($urandom) & 12'h00F;
               default: value = 12'h000;
            endcase
            dots     = 3'($urandom);
            blank_lz = 1'($urandom);
            load     = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
